physics_frame_sequencer: RTL and testbench

Frame-level controller for the four-particle soft-body datapath and its 16x16 LED occupancy renderer. It sets a fixed simulation period and issues a one-cycle step strobe to the particle array. It samples and holds the button inputs for each step, waits for the renderer to settle, and captures the rendered matrix into a stable frame buffer. The buffer is offered to the display driver over a valid/ready handshake, with frame and drop counters for debug.

---
 rtl/physics_frame_sequencer.sv | 142 ++++++++++++++
 tb/tb_physics_frame_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/physics_frame_sequencer.sv
// Frame controller for the soft-body particle array: periodic step strobe,
// per-step button capture, post-settle matrix capture and display handoff.
module physics_frame_sequencer #(
  parameter int WAIT_CYCLES   = 10000,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(WAIT_CYCLES+1)+1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         btn_left_in,
  input  logic         btn_right_in,
  input  logic         btn_up_in,
  input  logic         btn_down_in,
  input  logic [255:0] next_matrix,
  output logic         step,
  output logic         btn_left,
  output logic         btn_right,
  output logic         btn_up,
  output logic         btn_down,
  output logic [255:0] frame,
  output logic         frame_valid,
  input  logic         frame_ready,
  output logic [15:0]  frame_count,
  output logic [7:0]   drop_count,
  output logic         busy
);

  localparam int SET_W = $clog2(SETTLE_CYCLES+1)+1;

  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(WAIT_CYCLES-1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES-1);
  localparam logic [SET_W-1:0] SET_ONE     = SET_W'(1);

  localparam logic [2:0] S_WAIT    = 3'd0;
  localparam logic [2:0] S_STEP    = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_OFFER   = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] period_cnt;
  logic [SET_W-1:0] settle_cnt;

  logic [3:0] btn_raw;
  logic [3:0] btn_sync_p0;
  logic [3:0] btn_sync_p1;
  logic [3:0] btn_latch;
  logic [3:0] btn_hold;

  logic counting;
  logic expiry;
  logic load_btn;
  logic accept;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The period keeps running through an in-flight frame even when disabled,
  // so a sequence started before enable fell always completes on schedule.
  assign counting = enable || (state != S_WAIT);
  assign expiry   = counting && (period_cnt == PERIOD_LAST);
  assign load_btn = (state == S_WAIT) && expiry;
  assign accept   = frame_valid && frame_ready;

  assign btn_raw  = {btn_down_in, btn_up_in, btn_right_in, btn_left_in};

  assign step      = (state == S_STEP);
  assign busy      = (state == S_STEP) || (state == S_SETTLE) || (state == S_CAPTURE);
  assign btn_left  = btn_hold[0];
  assign btn_right = btn_hold[1];
  assign btn_up    = btn_hold[2];
  assign btn_down  = btn_hold[3];

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:    if (expiry) state_nxt = S_STEP;
      S_STEP:    state_nxt = S_SETTLE;
      S_SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_OFFER;
      S_OFFER:   if (accept) state_nxt = S_WAIT;
      default:   state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_WAIT;
      period_cnt <= '0;
      settle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (counting) period_cnt <= expiry ? '0 : period_cnt + CNT_ONE;
      if (state == S_STEP)        settle_cnt <= '0;
      else if (state == S_SETTLE) settle_cnt <= settle_cnt + SET_ONE;
    end
  end

  // Button synchronizer stages p0/p1; the hold register switches on the edge
  // into STEP so the particles see the new command during the strobe itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_sync_p0 <= '0;
      btn_sync_p1 <= '0;
      btn_latch   <= '0;
      btn_hold    <= '0;
    end else begin
      btn_sync_p0 <= btn_raw;
      btn_sync_p1 <= btn_sync_p0;
      if (load_btn) begin
        btn_hold  <= btn_latch | btn_sync_p1;
        btn_latch <= '0;
      end else begin
        btn_latch <= btn_latch | btn_sync_p1;
      end
    end
  end

  // Frame buffer and handshake; an expiry while still offering is a lost period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame       <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if (state == S_CAPTURE) begin
        frame       <= next_matrix;
        frame_count <= frame_count + 16'd1;
        frame_valid <= 1'b1;
      end else if ((state == S_OFFER) && accept) begin
        frame_valid <= 1'b0;
      end
      if ((state == S_OFFER) && expiry && !accept) drop_count <= sat_inc8(drop_count);
    end
  end

endmodule

// File: tb/tb_physics_frame_sequencer.sv
// Bench for physics_frame_sequencer with a timeline reference model.
module tb_physics_frame_sequencer;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b0;
  logic         btn_left_in = 1'b0;
  logic         btn_right_in = 1'b0;
  logic         btn_up_in = 1'b0;
  logic         btn_down_in = 1'b0;
  logic [255:0] next_matrix = '0;
  logic         frame_ready = 1'b0;
  logic         step, btn_left, btn_right, btn_up, btn_down;
  logic [255:0] frame;
  logic         frame_valid;
  logic [15:0]  frame_count;
  logic [7:0]   drop_count;
  logic         busy;

  physics_frame_sequencer #(.WAIT_CYCLES(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .btn_left_in(btn_left_in), .btn_right_in(btn_right_in),
    .btn_up_in(btn_up_in), .btn_down_in(btn_down_in),
    .next_matrix(next_matrix), .step(step),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .frame(frame), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_count(frame_count), .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference: m_since = cycles since the step strobe (-1 when no frame is
  // being built), m_offer = frame waiting for the display.
  int           m_cnt;
  int           m_since;
  bit           m_offer;
  logic [255:0] m_frame;
  logic [15:0]  m_fc;
  logic [7:0]   m_dc;
  logic [3:0]   m_btn, m_pend, m_s1, m_s2;

  logic [30:0] act_ctl;
  assign act_ctl = {step, btn_down, btn_up, btn_right, btn_left, frame_valid, busy,
                    frame_count, drop_count};

  function automatic logic [30:0] exp_ctl();
    return {(m_since == 0), m_btn, m_offer, (m_since >= 0), m_fc, m_dc};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_since = -1; m_offer = 0; m_frame = '0; m_fc = '0; m_dc = '0;
    m_btn = '0; m_pend = '0; m_s1 = '0; m_s2 = '0;
  endtask

  // Advance the model by one clock with the current inputs, then the DUT.
  task automatic tick();
    logic [3:0] raw;
    bit counting, expiry;
    raw = {btn_down_in, btn_up_in, btn_right_in, btn_left_in};
    counting = enable || (m_since >= 0) || m_offer;
    expiry = counting && (m_cnt == W-1);
    if (m_since < 0 && !m_offer && expiry) begin
      m_btn = m_pend | m_s2;
      m_pend = '0;
      m_since = 0;
    end else begin
      m_pend = m_pend | m_s2;
      if (m_since == S+1) begin
        m_frame = next_matrix; m_fc = m_fc + 16'd1; m_offer = 1; m_since = -1;
      end else if (m_since >= 0) begin
        m_since++;
      end else if (m_offer) begin
        if (frame_ready) m_offer = 0;
        else if (expiry && m_dc != 8'hFF) m_dc = m_dc + 8'd1;
      end
    end
    if (counting) m_cnt = expiry ? 0 : m_cnt + 1;
    m_s2 = m_s1;
    m_s1 = raw;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    enable = 1'b0; frame_ready = 1'b0; next_matrix = '0;
    {btn_down_in, btn_up_in, btn_right_in, btn_left_in} = '0;
    #2;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (act_ctl !== 31'd0) begin
      errors++; $display("FAIL reset_ctl got=%h want=0", act_ctl);
    end
    checks++;
    if (frame !== 256'd0) begin
      errors++; $display("FAIL reset_frame got=%h want=0", frame);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    enable = 1'b1; frame_ready = 1'b1;
    while (cyc < 56) begin
      next_matrix = {8{$urandom}};
      tick();
      checks++;
      if (act_ctl !== exp_ctl() || frame !== m_frame) begin
        errors++; $display("FAIL basic cyc=%0d ctl=%h want=%h frame=%h want=%h", cyc, act_ctl, exp_ctl(), frame, m_frame);
      end
      if (cyc == 16 || cyc == 32 || cyc == 48) begin
        checks++;
        if (step !== 1'b1) begin errors++; $display("FAIL basic_step cyc=%0d got=%b want=1", cyc, step); end
      end
      if (cyc == 22 || cyc == 38) begin
        checks++;
        if (frame_valid !== 1'b1) begin errors++; $display("FAIL basic_valid cyc=%0d got=%b want=1", cyc, frame_valid); end
      end
    end
    checks++;
    if (frame_count !== 16'd3 || drop_count !== 8'd0) begin
      errors++; $display("FAIL basic_counts fc=%0d dc=%0d want fc=3 dc=0", frame_count, drop_count);
    end
  endtask

  task automatic test_frame_hold();
    logic [255:0] a5;
    a5 = {32{8'hA5}};
    apply_reset();
    enable = 1'b1; frame_ready = 1'b0; next_matrix = a5;
    while (cyc < 22) begin
      tick();
      checks++;
      if (act_ctl !== exp_ctl() || frame !== m_frame) begin
        errors++; $display("FAIL hold_run cyc=%0d ctl=%h want=%h", cyc, act_ctl, exp_ctl());
      end
    end
    next_matrix = '0;
    repeat (5) begin
      tick();
      checks++;
      if (frame !== a5 || frame_valid !== 1'b1) begin
        errors++; $display("FAIL hold_frame cyc=%0d frame=%h valid=%b want a5.. valid=1", cyc, frame, frame_valid);
      end
    end
    frame_ready = 1'b1;
    tick();
    checks++;
    if (frame_valid !== 1'b0 || frame !== a5 || act_ctl !== exp_ctl()) begin
      errors++; $display("FAIL hold_accept valid=%b frame=%h want valid=0 frame a5..", frame_valid, frame);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    enable = 1'b1; frame_ready = 1'b0;
    while (cyc < 100) begin
      next_matrix = {8{$urandom}};
      frame_ready = (cyc >= 79);
      tick();
      checks++;
      if (act_ctl !== exp_ctl() || frame !== m_frame) begin
        errors++; $display("FAIL bp cyc=%0d ctl=%h want=%h", cyc, act_ctl, exp_ctl());
      end
      if (cyc == 64 || cyc == 99) begin
        checks++;
        if (drop_count !== 8'd3 || frame_count !== 16'd1) begin
          errors++; $display("FAIL bp_counts cyc=%0d dc=%0d fc=%0d want dc=3 fc=1", cyc, drop_count, frame_count);
        end
      end
      if (cyc == 96) begin
        checks++;
        if (step !== 1'b1) begin errors++; $display("FAIL bp_step cyc=96 got=%b want=1", step); end
      end
    end
  endtask

  task automatic test_buttons();
    apply_reset();
    enable = 1'b1; frame_ready = 1'b1;
    while (cyc < 56) begin
      btn_left_in = (cyc == 5 || cyc == 6 || cyc == 30);
      btn_up_in = (cyc == 40);
      btn_right_in = (cyc == 12);
      tick();
      checks++;
      if (act_ctl !== exp_ctl()) begin
        errors++; $display("FAIL btn cyc=%0d ctl=%h want=%h", cyc, act_ctl, exp_ctl());
      end
      if (cyc == 15 || cyc == 16 || cyc == 31 || cyc == 32 || cyc == 47 || cyc == 48) begin
        checks++;
        if (btn_left !== ((cyc == 16 || cyc == 31 || cyc == 48) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL btn_left cyc=%0d got=%b", cyc, btn_left);
        end
      end
    end
  endtask

  task automatic test_enable();
    int seen;
    apply_reset();
    enable = 1'b1; frame_ready = 1'b1;
    while (cyc < 60) begin
      if (cyc >= 18) enable = 1'b0;
      next_matrix = {8{$urandom}};
      tick();
      checks++;
      if (act_ctl !== exp_ctl() || frame !== m_frame) begin
        errors++; $display("FAIL en cyc=%0d ctl=%h want=%h", cyc, act_ctl, exp_ctl());
      end
      if (cyc >= 23 && step !== 1'b0) begin
        checks++; errors++; $display("FAIL en_nostep cyc=%0d got=1 want=0", cyc);
      end
    end
    checks++;
    if (frame_count !== 16'd1) begin errors++; $display("FAIL en_fc got=%0d want=1", frame_count); end
    enable = 1'b1;
    seen = -1;
    while (seen < 0 && cyc < 100) begin
      tick();
      checks++;
      if (act_ctl !== exp_ctl()) begin
        errors++; $display("FAIL en_resume cyc=%0d ctl=%h want=%h", cyc, act_ctl, exp_ctl());
      end
      if (step === 1'b1) seen = cyc;
    end
    checks++;
    if (seen != 69) begin errors++; $display("FAIL en_step_cycle got=%0d want=69", seen); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    enable = 1'b1; frame_ready = 1'b1;
    while (cyc < 52) begin
      btn_left_in = (cyc == 5 || cyc == 35);
      next_matrix = {8{$urandom}} | 256'd1;
      tick();
      checks++;
      if (act_ctl !== exp_ctl() || frame !== m_frame) begin
        errors++; $display("FAIL rmid_run cyc=%0d ctl=%h want=%h", cyc, act_ctl, exp_ctl());
      end
    end
    btn_left_in = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (act_ctl !== 31'd0 || frame !== 256'd0) begin
      errors++; $display("FAIL rmid_clear ctl=%h frame=%h want all 0", act_ctl, frame);
    end
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc = 0;
    while (cyc < 20) begin
      tick();
      checks++;
      if (act_ctl !== exp_ctl()) begin
        errors++; $display("FAIL rmid_after cyc=%0d ctl=%h want=%h", cyc, act_ctl, exp_ctl());
      end
      if (cyc == 16) begin
        checks++;
        if (step !== 1'b1) begin errors++; $display("FAIL rmid_step cyc=16 got=%b want=1", step); end
      end
    end
  endtask

  task automatic test_drop_saturation();
    apply_reset();
    enable = 1'b1; frame_ready = 1'b0;
    while (cyc < 260*W + 40) begin
      tick();
      checks++;
      if (act_ctl !== exp_ctl()) begin
        errors++; $display("FAIL sat cyc=%0d ctl=%h want=%h", cyc, act_ctl, exp_ctl());
      end
    end
    checks++;
    if (drop_count !== 8'hFF) begin errors++; $display("FAIL sat_dc got=%0d want=255", drop_count); end
  endtask

  task automatic test_random();
    apply_reset();
    enable = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 40) == 0) enable = ~enable;
      frame_ready = ($urandom_range(0, 3) != 0);
      btn_left_in = ($urandom_range(0, 9) == 0);
      btn_right_in = ($urandom_range(0, 9) == 0);
      btn_up_in = ($urandom_range(0, 9) == 0);
      btn_down_in = ($urandom_range(0, 9) == 0);
      next_matrix = {8{$urandom}};
      tick();
      checks++;
      if (act_ctl !== exp_ctl() || frame !== m_frame) begin
        errors++; $display("FAIL rand cyc=%0d ctl=%h want=%h", cyc, act_ctl, exp_ctl());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_frame_hold();
    test_backpressure();
    test_buttons();
    test_enable();
    test_reset_mid();
    test_drop_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
